// File: rtl/fetch_decode_unit_if.sv
// Bundles the two handshakes of the fetch/decode stage: the program-memory
// read port (req/ack) and the instruction issue port (valid/ready) toward
// the constant unit and the execute stage.
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 8
);
  // Program memory read port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [16:0]       mem_rdata;

  // Instruction issue port
  logic [16:0]       IM;
  logic              CS;
  logic              instr_valid;
  logic              instr_ready;
  logic [4:0]        opcode;
  logic [2:0]        rd;
  logic [2:0]        rs;

  // View from the fetch/decode unit
  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output IM, CS, instr_valid, opcode, rd, rs,
    input  instr_ready
  );

  // View from memory and the downstream consumers
  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  IM, CS, instr_valid, opcode, rd, rs,
    output instr_ready
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode stage: owns the PC, fetches 17-bit words over
// a req/ack port, holds them in the instruction register and issues them
// over valid/ready. CS pulses on the first issue cycle of immediate-class
// instructions. Redirects (pc_load) may arrive in any state; a request
// already on the memory bus is always allowed to finish (DISCARD).
module fetch_decode_unit #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic              IMM_OP_MSB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] PC,
  fetch_decode_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DISCARD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [16:0]       im_q, im_d;
  logic              cs_q, cs_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;

  // Next-state and next-output logic for the fetch/issue sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the value.
    state_d = state_q;
    pc_d    = pc_q;
    im_d    = im_q;
    cs_d    = 1'b0;  // strobe: only ever set on the FETCH->ISSUE transition
    valid_d = valid_q;
    req_d   = req_q;

    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_target;  // redirect while idle does not start a fetch
        end else if (run) begin
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (pc_load) begin
          pc_d = pc_target;
          // Data arriving with the redirect is dropped; without it the
          // request is still outstanding and must be drained first.
          if (!bus.mem_ack) state_d = S_DISCARD;
        end else if (bus.mem_ack) begin
          im_d    = bus.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          cs_d    = (bus.mem_rdata[16] == IMM_OP_MSB);
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (pc_load) begin
          // Whether or not ready is high, the issued word is finished with.
          pc_d    = pc_target;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          if (run) begin
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DISCARD: begin
        if (pc_load) pc_d = pc_target;  // latest target wins
        if (bus.mem_ack) state_d = S_FETCH;  // stale data ignored, req stays high
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      im_q    <= '0;
      cs_q    <= 1'b0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      im_q    <= im_d;
      cs_q    <= cs_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign PC              = pc_q;
  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.IM          = im_q;
  assign bus.CS          = cs_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = im_q[16:12];
  assign bus.rd          = im_q[11:9];
  assign bus.rs          = im_q[8:6];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit. The reference model is the
// instruction stream itself: issued words must be mem[a], mem[a+1], ...
// restarting at the target after every redirect and at RESET_PC after reset.
// A scoreboard queue holds the next expected issue; a monitor pops it when
// instr_valid rises.
module tb_fetch_decode_unit;
  localparam int         ADDR_W   = 8;
  localparam logic [7:0] RESET_PC = 8'h00;

  typedef struct {
    logic [7:0]  addr;
    logic [16:0] word;
    logic        cs;
    logic [7:0]  pc_next;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_target = '0;
  logic [7:0] pc_out;

  fetch_decode_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_decode_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .IMM_OP_MSB(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .PC       (pc_out),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_issued = 0;
  int          n_hs = 0;
  int          cyc = 0;
  int          lat = 1;  // 0 selects a random latency of 1..3 per request
  int          issue_cyc[$];
  logic [16:0] mem[256];
  exp_t        exp_q[$];
  logic [16:0] last_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t predict(input logic [7:0] a);
    exp_t e;
    e.addr    = a;
    e.word    = mem[a];
    e.cs      = mem[a][16];
    e.pc_next = a + 8'd1;
    return e;
  endfunction

  task automatic redirect(input logic [7:0] t);
    exp_q.delete();
    exp_q.push_back(predict(t));
  endtask

  task automatic wait_issues(input int n, input int budget, input string name);
    int target;
    int k;
    target = n_issued + n;
    k = 0;
    while (n_issued < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(n_issued >= target), 32'd1);
  endtask

  // Cycle counter and handshake counter (values sampled before the edge).
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && bus.instr_valid && bus.instr_ready) n_hs++;
  end

  // Program memory: captures the address when a request is seen, answers
  // with a single-cycle ack after the chosen latency.
  initial begin
    logic       busy;
    int         cnt;
    logic [7:0] a;
    busy = 1'b0;
    cnt = 0;
    a = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        check("mem_req_held", 32'(bus.mem_req), 32'd1);
        if (cnt == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem[a];
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.mem_req) begin
        busy = 1'b1;
        a = bus.mem_addr;
        cnt = (lat == 0) ? int'($urandom_range(0, 2)) : lat - 1;
      end
    end
  end

  // Monitor: scores each newly presented instruction and the steady-state rules.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.instr_valid && !prev_valid) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_im", 32'(bus.IM), 32'(e.word));
            check("issue_cs", 32'(bus.CS), 32'(e.cs));
            check("issue_opcode", 32'(bus.opcode), 32'(e.word[16:12]));
            check("issue_rd", 32'(bus.rd), 32'(e.word[11:9]));
            check("issue_rs", 32'(bus.rs), 32'(e.word[8:6]));
            check("issue_pc", 32'(pc_out), 32'(e.pc_next));
            last_word = e.word;
            exp_q.push_back(predict(e.addr + 8'd1));
          end
          n_issued++;
          issue_cyc.push_back(cyc);
        end else begin
          check("cs_low", 32'(bus.CS), 32'd0);
          if (bus.instr_valid) begin
            check("stall_im_stable", 32'(bus.IM), 32'(last_word));
            check("stall_no_req", 32'(bus.mem_req), 32'd0);
          end
        end
        prev_valid = bus.instr_valid;
      end
    end
  end

  // Watchdog: ends the run if the stimulus ever stops making progress.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, issued=%0d", n_issued);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [16:0] im_before;
    int          hs_before;
    int          k;

    for (int i = 0; i < 256; i++) mem[i] = {1'($urandom), 8'(i), 8'($urandom)};
    mem[0] = 17'h10005;
    mem[1] = 17'h0ABCD;
    exp_q.push_back(predict(RESET_PC));
    bus.instr_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'(RESET_PC));
    check("rst_im", 32'(bus.IM), 32'd0);
    check("rst_cs", 32'(bus.CS), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);

    // Boot: single-cycle ack, consumer always ready
    rst_n = 1'b1;
    run = 1'b1;
    bus.instr_ready = 1'b1;
    lat = 1;
    k = 0;
    while (!bus.mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("first_req", 32'(bus.mem_req), 32'd1);
    check("first_addr", 32'(bus.mem_addr), 32'd0);
    wait_issues(3, 50, "boot_issues");
    check("issue_spacing", 32'(issue_cyc[2] - issue_cyc[1]), 32'd3);

    // Stall in ISSUE for several cycles
    @(negedge clk);
    bus.instr_ready = 1'b0;
    wait_issues(1, 40, "stall_issue");
    hs_before = n_hs;
    repeat (4) @(negedge clk);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    check("stall_no_hs", 32'(n_hs), 32'(hs_before));
    bus.instr_ready = 1'b1;

    // Redirect while FETCH waits on a slow ack
    lat = 3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.mem_req && !bus.mem_ack && !bus.instr_valid) && k < 30);
    check("discard_setup", 32'(bus.mem_req && !bus.mem_ack), 32'd1);
    pc_target = 8'h40;
    pc_load = 1'b1;
    @(posedge clk);
    redirect(8'h40);
    #1 pc_load = 1'b0;
    check("discard_req_held", 32'(bus.mem_req), 32'd1);
    wait_issues(1, 40, "discard_issue");

    // Redirect coincident with mem_ack
    lat = 2;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.mem_ack && !bus.instr_valid) && k < 30);
    check("ackredir_setup", 32'(bus.mem_ack), 32'd1);
    im_before = bus.IM;
    pc_target = 8'h80;
    pc_load = 1'b1;
    @(posedge clk);
    redirect(8'h80);
    #1 pc_load = 1'b0;
    check("ackredir_im", 32'(bus.IM), 32'(im_before));
    check("ackredir_req", 32'(bus.mem_req), 32'd1);
    check("ackredir_addr", 32'(bus.mem_addr), 32'h80);
    wait_issues(1, 40, "ackredir_issue");

    // Redirect coincident with instr_ready, then wrap through 0xFF
    lat = 1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.instr_valid && k < 30);
    check("hsredir_setup", 32'(bus.instr_valid), 32'd1);
    hs_before = n_hs;
    bus.instr_ready = 1'b1;
    pc_target = 8'hFE;
    pc_load = 1'b1;
    @(posedge clk);
    redirect(8'hFE);
    #1 pc_load = 1'b0;
    check("hsredir_counted", 32'(n_hs), 32'(hs_before + 1));
    check("hsredir_valid", 32'(bus.instr_valid), 32'd0);
    wait_issues(3, 60, "wrap_issues");

    // run low: finish current instruction then idle; redirect while idle
    @(negedge clk);
    run = 1'b0;
    wait_issues(1, 40, "run_low_issue");
    repeat (5) @(negedge clk);
    check("idle_no_req", 32'(bus.mem_req), 32'd0);
    check("idle_no_valid", 32'(bus.instr_valid), 32'd0);
    pc_target = 8'h10;
    pc_load = 1'b1;
    @(posedge clk);
    redirect(8'h10);
    #1 pc_load = 1'b0;
    check("idle_redir_pc", 32'(pc_out), 32'h10);
    @(negedge clk);
    check("idle_redir_no_req", 32'(bus.mem_req), 32'd0);
    run = 1'b1;
    wait_issues(1, 40, "idle_restart_issue");

    // Asynchronous reset in the middle of a fetch
    lat = 3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.mem_req && !bus.mem_ack) && k < 30);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.mem_req), 32'd0);
    check("arst_pc", 32'(pc_out), 32'(RESET_PC));
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_im", 32'(bus.IM), 32'd0);
    redirect(RESET_PC);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    wait_issues(2, 50, "post_reset_issues");

    // Randomized traffic
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      run = ($urandom_range(0, 7) != 0);
      bus.instr_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        pc_target = 8'($urandom);
        pc_load = 1'b1;
      end
      @(posedge clk);
      if (pc_load) redirect(pc_target);
      #1 pc_load = 1'b0;
    end

    @(negedge clk);
    run = 1'b1;
    bus.instr_ready = 1'b1;
    wait_issues(2, 80, "final_issues");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
